// File: rtl/ddr2_rd_arbiter.sv
// Shares the ddr2_mgr read port among NUM_REQ readers, round-robin, one transfer at a time.
// Define DDR2_RD_ARB_PRIO0_EN to give requester 0 priority over a rotating group of the rest.
module ddr2_rd_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 25,
  parameter int LEN_W       = 10,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_vec,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        grant_vec,
  output logic [NUM_REQ-1:0]        data_valid_vec,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        done_vec,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LEN_W-1:0]          mem_xfr_len,
  input  logic                      mem_grant,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_data_valid,
  output logic [1:0]                owner,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, XFR, DONE} state_t;

  localparam int         PW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] NREQ = 3'(NUM_REQ);
  localparam logic [1:0] LAST = 2'(NUM_REQ - 1);

  state_t              state_q;
  logic [1:0]          ptr_q, owner_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [PW-1:0]       prog_q;
  logic [NUM_REQ-1:0]  grant_q, dv_q, done_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                mem_req_q, terr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LEN_W-1:0]    mem_len_q;

  logic [2:0]          pick_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [LEN_W-1:0]    sel_len_d;
  logic [NUM_REQ-1:0]  owner_oh, pick_oh;
  logic                tmo;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [LEN_W-1:0]    len_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
      assign owner_oh[gi] = (owner_q == 2'(gi));
      assign pick_oh[gi]  = (pick_d[1:0] == 2'(gi));
    end
  endgenerate

  // Returns {found, index} of the first set bit of v at or after p, wrapping within n entries.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p,
                                         input logic [2:0] n);
    logic [2:0] s;
    rr_pick = '0;
    for (int k = 3; k >= 0; k--) begin
      s = {1'b0, p} + 3'(k);
      if (s >= n) s = s - n;
      if ((3'(k) < n) && v[s[1:0]]) rr_pick = {1'b1, s[1:0]};
    end
  endfunction

`ifdef DDR2_RD_ARB_PRIO0_EN
  logic [1:0] oth_q;
  logic [2:0] pick_oth;
  // Requester 0 yields exactly one turn to the others right after it was served.
  always_comb begin
    pick_oth = rr_pick(4'(req_vec >> 1), oth_q, NREQ - 3'd1);
    if (req_vec[0] && !(ptr_q == 2'd1 && pick_oth[2])) pick_d = 3'b100;
    else                                               pick_d = {pick_oth[2], pick_oth[1:0] + 2'd1};
  end
`else
  always_comb pick_d = rr_pick(4'(req_vec), ptr_q, NREQ);
`endif

  always_comb begin
    sel_addr_d = addr_arr[pick_d[1:0]];
    sel_len_d  = len_arr[pick_d[1:0]];
  end

  assign tmo = (prog_q == PW'(TIMEOUT_CYC - 1)) && !mem_grant && !mem_data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      prog_q     <= '0;
      grant_q    <= '0;
      dv_q       <= '0;
      done_q     <= '0;
      rd_data_q  <= '0;
      mem_req_q  <= 1'b0;
      terr_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_len_q  <= '0;
`ifdef DDR2_RD_ARB_PRIO0_EN
      oth_q      <= '0;
`endif
    end else begin
      grant_q <= '0;
      dv_q    <= '0;
      done_q  <= '0;
      prog_q  <= (mem_grant || mem_data_valid) ? '0 : prog_q + PW'(1);
      case (state_q)
        IDLE: begin
          prog_q <= '0;
          if (pick_d[2]) begin
            owner_q    <= pick_d[1:0];
            mem_addr_q <= sel_addr_d;
            mem_len_q  <= sel_len_d;
            cnt_q      <= sel_len_d;
            if (sel_len_d == '0) begin
              grant_q <= pick_oh;
              state_q <= DONE;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= WAIT_GRANT;
            end
          end
        end
        WAIT_GRANT: begin
          if (mem_grant) begin
            mem_req_q <= 1'b0;
            grant_q   <= owner_oh;
            state_q   <= XFR;
          end else if ((req_vec & owner_oh) == '0) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (tmo) begin
            mem_req_q <= 1'b0;
            terr_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        XFR: begin
          if (mem_data_valid) begin
            rd_data_q <= mem_data;
            dv_q      <= owner_oh;
            cnt_q     <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_q <= DONE;
          end else if (tmo) begin
            terr_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= owner_oh;
          ptr_q   <= (owner_q == LAST) ? 2'd0 : owner_q + 2'd1;
`ifdef DDR2_RD_ARB_PRIO0_EN
          if (owner_q != 2'd0) oth_q <= (owner_q == LAST) ? 2'd0 : owner_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_vec      = grant_q;
  assign data_valid_vec = dv_q;
  assign done_vec       = done_q;
  assign rd_data        = rd_data_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign mem_xfr_len    = mem_len_q;
  assign owner          = owner_q;
  assign busy           = (state_q != IDLE);
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_ddr2_rd_arbiter.sv
// Directed plus randomized bench for ddr2_rd_arbiter against an arbitration reference model.
module tb_ddr2_rd_arbiter;
  localparam int N = 3, AW = 25, LW = 10, DW = 32, TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vec;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    grant_vec, data_valid_vec, done_vec;
  logic [DW-1:0]   rd_data, mem_data;
  logic            mem_req, mem_grant, mem_data_valid, busy, timeout_err;
  logic [AW-1:0]   mem_addr;
  logic [LW-1:0]   mem_xfr_len;
  logic [1:0]      owner;

  int n_err = 0, n_chk = 0;
  int m_ptr, m_last, m_oth;
  logic [AW-1:0] a_tab [N];
  logic [LW-1:0] l_tab [N];

  always #5 clk = ~clk;

  ddr2_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_vec(req_vec), .req_addr(req_addr), .req_len(req_len),
    .grant_vec(grant_vec), .data_valid_vec(data_valid_vec), .rd_data(rd_data),
    .done_vec(done_vec), .mem_req(mem_req), .mem_addr(mem_addr), .mem_xfr_len(mem_xfr_len),
    .mem_grant(mem_grant), .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({grant_vec, data_valid_vec, rd_data, done_vec, mem_req, mem_addr,
                 mem_xfr_len, owner, busy, timeout_err});
  endfunction

  task automatic pack();
    req_addr = {a_tab[2], a_tab[1], a_tab[0]};
    req_len  = {l_tab[2], l_tab[1], l_tab[0]};
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_last = -1; m_oth = 1;
  endfunction

  // Winner for a request set: plain rotation from the pointer, or display-first with one-turn yield.
  function automatic int model_pick(input logic [N-1:0] r);
    int rv = int'(r);
    int i;
`ifdef DDR2_RD_ARB_PRIO0_EN
    if ((rv & 1) != 0 && !(m_last == 0 && (rv >> 1) != 0)) return 0;
    for (int k = 0; k < N - 1; k++) begin
      i = 1 + (m_oth - 1 + k) % (N - 1);
      if (((rv >> i) & 1) != 0) return i;
    end
    return 0;
`else
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (((rv >> i) & 1) != 0) return i;
    end
    return -1;
`endif
  endfunction

  function automatic void model_done(input int w);
    m_ptr  = (w + 1) % N;
    m_last = w;
    if (w != 0) m_oth = (w == N - 1) ? 1 : w + 1;
  endfunction

  // One full transaction as seen by requester and ddr2_mgr; one line printed per transaction.
  task automatic txn(input logic [N-1:0] reqs, input bit hold, input int gdly,
                     input bit fixed, input logic [DW-1:0] fdat, output int got);
    int w, gap, nb;
    logic [N-1:0] woh;
    logic [DW-1:0] d;
    w = model_pick(reqs);
    woh = N'(1 << w);
    req_vec = reqs;
    pack();
    @(negedge clk);
    got = int'(owner);
    chk("arb_owner", 128'(owner), 128'(w));
    if (l_tab[w] == '0) begin
      chk("zl_grant", 128'({grant_vec, mem_req, busy}), 128'({woh, 1'b0, 1'b1}));
      if (!hold) req_vec = '0;
      @(negedge clk);
      chk("zl_done", 128'({done_vec, grant_vec, mem_req, busy}), 128'({woh, N'(0), 1'b0, 1'b0}));
    end else begin
      chk("wg_start", 128'({mem_req, mem_addr, mem_xfr_len, busy}),
          128'({1'b1, a_tab[w], l_tab[w], 1'b1}));
      for (int i = 0; i < gdly; i++) @(negedge clk);
      chk("wg_hold", 128'({mem_req, grant_vec}), 128'({1'b1, N'(0)}));
      mem_grant = 1'b1;
      @(negedge clk);
      mem_grant = 1'b0;
      chk("grant", 128'({grant_vec, mem_req}), 128'({woh, 1'b0}));
      if (!hold) req_vec = '0;
      nb = int'(l_tab[w]);
      for (int b = 0; b < nb; b++) begin
        gap = fixed ? 0 : int'($urandom_range(2));
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("beat_gap", 128'(data_valid_vec), 128'(0));
        end
        d = fixed ? fdat : DW'($urandom);
        mem_data = d;
        mem_data_valid = 1'b1;
        @(negedge clk);
        mem_data_valid = 1'b0;
        chk("beat", 128'({data_valid_vec, rd_data}), 128'({woh, d}));
      end
      @(negedge clk);
      chk("done", 128'({done_vec, data_valid_vec, busy}), 128'({woh, N'(0), 1'b0}));
    end
    model_done(w);
    $display("txn req=%b owner=%0d len=%0d", reqs, got, l_tab[w]);
  endtask

  initial begin
    int got;
    int fair_exp [6];
    logic [DW-1:0] d;
`ifdef DDR2_RD_ARB_PRIO0_EN
    fair_exp = '{0, 1, 0, 2, 0, 1};
`else
    fair_exp = '{0, 1, 2, 0, 1, 2};
`endif
    rst = 1'b1; req_vec = '0; mem_grant = 1'b0; mem_data_valid = 1'b0; mem_data = '0;
    for (int i = 0; i < N; i++) begin a_tab[i] = '0; l_tab[i] = '0; end
    pack();
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Fairness with all three requesting continuously.
    for (int i = 0; i < N; i++) begin a_tab[i] = AW'($urandom); l_tab[i] = LW'(2); end
    for (int t = 0; t < 6; t++) begin
      txn(3'b111, 1'b1, int'($urandom_range(3)), 1'b0, '0, got);
      chk("fair_order", 128'(got), 128'(fair_exp[t]));
    end
    req_vec = '0;

    // Single requester with fixed address, length and data.
    a_tab[0] = 25'h0001200; l_tab[0] = LW'(4);
    txn(3'b001, 1'b0, 3, 1'b1, 32'hFDCB8610, got);

    // Zero length on requester 1.
    l_tab[1] = '0;
    txn(3'b010, 1'b0, 0, 1'b0, '0, got);

    // Requester 2 withdraws before the grant arrives.
    a_tab[2] = 25'h0ABCDE; l_tab[2] = LW'(5);
    req_vec = 3'b100;
    pack();
    @(negedge clk);
    chk("wd_start", 128'({owner, mem_req}), 128'({2'd2, 1'b1}));
    @(negedge clk);
    req_vec = '0;
    @(negedge clk);
    chk("wd_drop", 128'({mem_req, busy}), 128'(0));
    @(negedge clk);
    chk("wd_no_done", 128'({done_vec, grant_vec}), 128'(0));
    $display("txn req=100 withdrawn");

    // Randomized traffic; the first request after the withdraw probes the unchanged pointer.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        a_tab[i] = AW'($urandom);
        l_tab[i] = ($urandom_range(5) == 0) ? '0 : LW'($urandom_range(1, 4));
      end
      txn((t == 0) ? 3'b111 : N'($urandom_range(1, 7)), 1'($urandom_range(1)),
          int'($urandom_range(5)), 1'b0, '0, got);
    end
    req_vec = '0;
    @(negedge clk);

    // Timeout: ddr2_mgr never grants requester 1.
    a_tab[1] = AW'($urandom); l_tab[1] = LW'(4);
    req_vec = 3'b010;
    pack();
    got = 0;
    @(negedge clk);
    while (mem_req === 1'b1 && got < 3 * TMO) begin
      got++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", 128'(got), 128'(TMO));
    chk("tmo_err", 128'(timeout_err), 128'(1));
    req_vec = '0;
    @(negedge clk);
    chk("tmo_done", 128'({done_vec, mem_req}), 128'({3'b010, 1'b0}));
    model_done(1);
    $display("txn req=010 timed out after %0d cycles", got);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) begin a_tab[i] = AW'($urandom); l_tab[i] = LW'($urandom_range(1, 3)); end
      txn(N'($urandom_range(1, 7)), 1'b0, int'($urandom_range(4)), 1'b0, '0, got);
    end
    chk("tmo_sticky", 128'(timeout_err), 128'(1));

    // Reset after beat 2 of 8; remaining beats must not reach the requester.
    a_tab[0] = AW'($urandom); l_tab[0] = LW'(8);
    req_vec = 3'b001;
    pack();
    @(negedge clk);
    mem_grant = 1'b1;
    @(negedge clk);
    mem_grant = 1'b0;
    req_vec = '0;
    for (int b = 0; b < 2; b++) begin
      d = DW'($urandom);
      mem_data = d;
      mem_data_valid = 1'b1;
      @(negedge clk);
      chk("rst_pre_beat", 128'({data_valid_vec, rd_data}), 128'({3'b001, d}));
    end
    rst = 1'b1;
    mem_data = DW'($urandom);
    @(negedge clk);
    chk("rst_outs", all_outs(), 128'(0));
    rst = 1'b0;
    model_reset();
    for (int b = 0; b < 5; b++) begin
      mem_data = DW'($urandom);
      @(negedge clk);
      chk("rst_drop_beat", 128'({data_valid_vec, busy, done_vec}), 128'(0));
    end
    mem_data_valid = 1'b0;
    $display("txn req=001 reset mid-transfer");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
